// File: rtl/common_dffcam_lookup_alloc.sv
// Lookup-or-allocate front-end for a DFF CAM: hit returns the matching index, miss writes a victim.
// Optional COMMON_DFFCAM_LOOKUP_ALLOC_FREE_FIRST_EN: shadow valid map, victim = lowest free entry.
//
// state  | meaning
// IDLE   | ready for a key; invalidates accepted
// LOOKUP | CAM queried with key_q; miss writes victim entry
// RESP   | response held until rsp_ready; invalidates accepted
module common_dffcam_lookup_alloc #(
  parameter int  CAM_DEPTH = 8,
  parameter int  CAM_WIDTH = 16,
  localparam int AW        = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CAM_WIDTH-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AW-1:0]        rsp_idx,
  output logic                 rsp_hit,
  input  logic                 inv_valid,
  output logic                 inv_ready,
  input  logic [AW-1:0]        inv_idx,
  output logic [AW-1:0]        cam_addr,
  output logic                 cam_en,
  output logic                 cam_we,
  output logic [CAM_WIDTH-1:0] cam_din,
  output logic                 cam_din_valid,
  output logic [CAM_WIDTH-1:0] cam_qdata,
  input  logic [AW-1:0]        cam_qaddr,
  input  logic                 cam_qvalid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CAM_WIDTH-1:0] key_q, key_d;
  logic [AW-1:0]        victim_q, victim_d;
  logic [AW-1:0]        rsp_idx_q, rsp_idx_d;
  logic                 rsp_hit_q, rsp_hit_d;

  logic          req_fire;
  logic          inv_fire;
  logic          inv_in_range;
  logic          lookup_miss;
  logic          victim_adv;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] victim_next;

  assign req_ready = (state_q == ST_IDLE);
  assign inv_ready = (state_q != ST_LOOKUP);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_idx   = rsp_idx_q;
  assign rsp_hit   = rsp_hit_q;
  assign cam_qdata = key_q;

  assign req_fire     = req_valid & req_ready;
  // Gated by reset so no CAM write can slip out while reset is held.
  assign inv_fire     = inv_valid & inv_ready & reset;
  assign inv_in_range = (int'(inv_idx) < CAM_DEPTH);
  assign lookup_miss  = (state_q == ST_LOOKUP) & ~cam_qvalid;
  assign victim_next  = (victim_q == AW'(CAM_DEPTH - 1)) ? '0 : victim_q + AW'(1);

`ifdef COMMON_DFFCAM_LOOKUP_ALLOC_FREE_FIRST_EN
  logic [CAM_DEPTH-1:0] vmap_q, vmap_d;
  logic                 free_found;
  logic [AW-1:0]        free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!vmap_q[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  assign alloc_idx  = free_found ? free_idx : victim_q;
  // Round-robin pointer only moves when the table is full.
  assign victim_adv = lookup_miss & ~free_found;

  always_comb begin
    vmap_d = vmap_q;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      if (lookup_miss && alloc_idx == AW'(i)) begin
        vmap_d[i] = 1'b1;
      end
      if (inv_fire && inv_in_range && inv_idx == AW'(i)) begin
        vmap_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vmap_q <= '0;
    end else begin
      vmap_q <= vmap_d;
    end
  end
`else
  assign alloc_idx  = victim_q;
  assign victim_adv = lookup_miss;
`endif

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    rsp_idx_d = rsp_idx_q;
    rsp_hit_d = rsp_hit_q;
    victim_d  = victim_adv ? victim_next : victim_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          key_d   = req_key;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cam_qvalid) begin
          rsp_idx_d = cam_qaddr;
          rsp_hit_d = 1'b1;
        end else begin
          rsp_idx_d = alloc_idx;
          rsp_hit_d = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Invalidates are never accepted in LOOKUP, so the two writers never collide.
  always_comb begin
    cam_en        = 1'b0;
    cam_we        = 1'b0;
    cam_addr      = '0;
    cam_din       = '0;
    cam_din_valid = 1'b0;
    if (lookup_miss) begin
      cam_en        = 1'b1;
      cam_we        = 1'b1;
      cam_addr      = alloc_idx;
      cam_din       = key_q;
      cam_din_valid = 1'b1;
    end else if (inv_fire && inv_in_range) begin
      cam_en   = 1'b1;
      cam_we   = 1'b1;
      cam_addr = inv_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      victim_q  <= '0;
      rsp_idx_q <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      victim_q  <= victim_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_hit_q <= rsp_hit_d;
    end
  end

endmodule

// File: tb/tb_common_dffcam_lookup_alloc.sv
// Self-checking bench for common_dffcam_lookup_alloc with a behavioural CAM and reference allocator.
// Build with COMMON_DFFCAM_LOOKUP_ALLOC_FREE_FIRST_EN to check the free-first victim policy.
module tb_common_dffcam_lookup_alloc;

  localparam int DEPTH = 6;
  localparam int W     = 16;
  localparam int AW    = 3;

  logic          clk;
  logic          reset;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_key;
  logic          rsp_valid, rsp_ready;
  logic [AW-1:0] rsp_idx;
  logic          rsp_hit;
  logic          inv_valid, inv_ready;
  logic [AW-1:0] inv_idx;
  logic [AW-1:0] cam_addr;
  logic          cam_en, cam_we;
  logic [W-1:0]  cam_din;
  logic          cam_din_valid;
  logic [W-1:0]  cam_qdata;
  logic [AW-1:0] cam_qaddr;
  logic          cam_qvalid;

  int n_tests = 0;
  int n_fail  = 0;

  common_dffcam_lookup_alloc #(.CAM_DEPTH(DEPTH), .CAM_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_hit(rsp_hit),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_idx(inv_idx),
    .cam_addr(cam_addr), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
    .cam_din_valid(cam_din_valid), .cam_qdata(cam_qdata),
    .cam_qaddr(cam_qaddr), .cam_qvalid(cam_qvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM attached to the DUT; valid bits reset to zero.
  logic [W-1:0]     cam_key [DEPTH];
  logic [DEPTH-1:0] cam_vld;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cam_vld <= '0;
    end else if (cam_en && cam_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(cam_addr) == i) begin
          cam_key[i] <= cam_din;
          cam_vld[i] <= cam_din_valid;
        end
      end
    end
  end

  always_comb begin
    cam_qvalid = 1'b0;
    cam_qaddr  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_key[i] == cam_qdata) begin
        cam_qvalid = 1'b1;
        cam_qaddr  = AW'(i);
      end
    end
  end

  // Reference model: which key lives in which entry, plus round-robin pointer.
  int m_key [DEPTH];
  bit m_vld [DEPTH];
  int m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic void model_inv(input int idx);
    if (idx < DEPTH) m_vld[idx] = 1'b0;
  endfunction

  function automatic int model_victim();
    int v;
    v = -1;
`ifdef COMMON_DFFCAM_LOOKUP_ALLOC_FREE_FIRST_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_vld[i] && v < 0) v = i;
    end
`endif
    if (v < 0) begin
      v    = m_rr;
      m_rr = (m_rr + 1) % DEPTH;
    end
    return v;
  endfunction

  // Returns {hit, idx} and updates the model's table.
  function automatic void model_lookup(input int key, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && m_key[i] == key) begin
        hit = 1'b1;
        idx = i;
      end
    end
    if (!hit) begin
      idx        = model_victim();
      m_key[idx] = key;
      m_vld[idx] = 1'b1;
    end
  endfunction

  task automatic chk_inv_write(input string tag, input int idx);
    chk({tag, "_inv_ready"}, 32'(inv_ready), 1);
    if (idx < DEPTH) begin
      chk({tag, "_inv_en"}, 32'(cam_en), 1);
      chk({tag, "_inv_we"}, 32'(cam_we), 1);
      chk({tag, "_inv_addr"}, 32'(cam_addr), 32'(idx));
      chk({tag, "_inv_dv"}, 32'(cam_din_valid), 0);
      chk({tag, "_inv_din"}, 32'(cam_din), 0);
    end else begin
      chk({tag, "_inv_oor_en"}, 32'(cam_en), 0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_idx", 32'(rsp_idx), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_inv_ready", 32'(inv_ready), 1);
    chk("rst_cam_en", 32'(cam_en), 0);
    chk("rst_qdata", 32'(cam_qdata), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_inv(input int idx);
    @(negedge clk);
    inv_valid = 1'b1;
    inv_idx   = AW'(idx);
    #1 chk_inv_write("inv", idx);
    @(posedge clk);
    model_inv(idx);
    @(negedge clk);
    inv_valid = 1'b0;
  endtask

  // inv_mode: 0 none, 1 invalidate in the accept cycle, 2 invalidate during RESP (inv_i<0: returned idx)
  task automatic do_req(input logic [W-1:0] key, input int hold, input int inv_mode, input int inv_i);
    bit exp_hit;
    int exp_idx;
    int ii;
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = key;
    if (inv_mode == 1) begin
      inv_valid = 1'b1;
      inv_idx   = AW'(inv_i);
    end
    #1 chk("acc_req_ready", 32'(req_ready), 1);
    if (inv_mode == 1) chk_inv_write("acc", inv_i);
    @(posedge clk);
    if (inv_mode == 1) model_inv(inv_i);
    model_lookup(int'(key), exp_hit, exp_idx);
    @(negedge clk);
    req_valid = 1'b0;
    inv_valid = 1'b0;
    #1;
    chk("lk_req_ready", 32'(req_ready), 0);
    chk("lk_inv_ready", 32'(inv_ready), 0);
    chk("lk_rsp_valid", 32'(rsp_valid), 0);
    chk("lk_qdata", 32'(cam_qdata), 32'(key));
    chk("lk_cam_en", 32'(cam_en), exp_hit ? 0 : 1);
    if (!exp_hit) begin
      chk("lk_cam_we", 32'(cam_we), 1);
      chk("lk_cam_addr", 32'(cam_addr), 32'(exp_idx));
      chk("lk_cam_din", 32'(cam_din), 32'(key));
      chk("lk_cam_dv", 32'(cam_din_valid), 1);
    end
    @(negedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_idx", 32'(rsp_idx), 32'(exp_idx));
    chk("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
    chk("rsp_req_ready", 32'(req_ready), 0);
    for (int h = 0; h < hold; h++) begin
      if (inv_mode == 2 && h == 0) begin
        ii        = (inv_i < 0) ? exp_idx : inv_i;
        inv_valid = 1'b1;
        inv_idx   = AW'(ii);
        #1 chk_inv_write("resp", ii);
      end
      @(posedge clk);
      if (inv_mode == 2 && h == 0) model_inv(ii);
      @(negedge clk);
      inv_valid = 1'b0;
      #1;
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_idx", 32'(rsp_idx), 32'(exp_idx));
      chk("hold_hit", 32'(rsp_hit), 32'(exp_hit));
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("done_rsp_valid", 32'(rsp_valid), 0);
    chk("done_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_key   = '0;
    rsp_ready = 1'b0;
    inv_valid = 1'b0;
    inv_idx   = '0;
    model_reset();
    apply_reset();

    // T1 / T2: first miss allocates entry 0, repeat key hits.
    do_req(16'h1234, 0, 0, 0);
    do_req(16'h1234, 0, 0, 0);

    // T3: fill all six entries and wrap back to 0.
    for (int k = 1; k <= 6; k++) do_req(16'h2000 + 16'(k), 0, 0, 0);
    do_req(16'h1234, 0, 0, 0);

    // T4: hole left by an invalidate.
    apply_reset();
    do_req(16'h3001, 0, 0, 0);
    do_req(16'h3002, 0, 0, 0);
    do_req(16'h3003, 0, 0, 0);
    do_inv(1);
    do_req(16'h3004, 0, 0, 0);

    // T5: long backpressure, invalidate of the returned index during RESP.
    do_req(16'h3003, 5, 2, -1);
    do_req(16'h3003, 5, 0, 0);
    // Invalidate in the accept cycle hides the entry from the following lookup.
    do_req(16'h3001, 0, 1, 0);
    do_inv(7);
    do_inv(6);

    // T6: reset while a miss write is being driven.
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("t6_lk_cam_en", 32'(cam_en), 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_cam_en", 32'(cam_en), 0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rst_req_ready", 32'(req_ready), 1);
    model_reset();
    repeat (3) @(negedge clk);
    #1 chk("t6_hold_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    do_req(16'h7777, 0, 0, 0);
    do_req(16'h7778, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 7) begin
        do_req(16'hA000 + 16'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 7)));
      end else begin
        do_inv(int'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
